// File: rtl/sig_lvl_detect_pkg.sv
// Shared level-handling helpers: polarity decoding and the debounce FSM state type.
// Polarity parameters are 32-bit packed ASCII ("HIGH", or "LOW" right-justified).
package common_functions;

  localparam logic [31:0] LvlHigh = "HIGH";
  localparam logic [31:0] LvlLow  = {8'h00, "LOW"};

  typedef enum logic [1:0] {
    S_INACT    = 2'd0,
    S_TO_ACT   = 2'd1,
    S_ACT      = 2'd2,
    S_TO_INACT = 2'd3
  } t_lvl_state;

  function automatic logic lvl_is_legal(logic [31:0] lvl);
    return (lvl == LvlHigh) || (lvl == LvlLow);
  endfunction

  function automatic logic set_sig_lvl(logic [31:0] lvl);
    return (lvl == LvlHigh);
  endfunction

  function automatic logic lvl_is_active(logic raw, logic [31:0] p_active_lvl);
    return (raw == set_sig_lvl(p_active_lvl));
  endfunction

endpackage

// File: rtl/sig_lvl_detect_sync.sv
// N-stage synchroniser for a single asynchronous bit, with a selectable reset value.
module sig_sync #(
  parameter int unsigned P_STAGES  = 2,
  parameter logic        P_RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  if (P_STAGES < 2) begin : g_bad_stages
    $fatal(1, "sig_sync: P_STAGES must be >= 2");
  end

  logic [P_STAGES-1:0] sync_q;
  logic [P_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[P_STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {P_STAGES{P_RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[P_STAGES-1];

endmodule

// File: rtl/sig_lvl_detect.sv
// Synchronises and debounces an asynchronous level, reports it as a logical active flag
// with one-cycle edge pulses and a saturating assertion counter.
module sig_lvl_detect
  import common_functions::*;
#(
  parameter logic [31:0] P_ACTIVE_LVL   = LvlHigh,
  parameter logic [31:0] P_RST_LVL      = LvlLow,
  parameter int unsigned P_SYNC_STAGES  = 2,
  parameter int unsigned P_DEBOUNCE_CYC = 16,
  parameter int unsigned P_CNT_W        = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sig,
  input  logic               i_clr_cnt,
  output logic               o_active,
  output logic               o_stable,
  output logic               o_assert_p,
  output logic               o_deassert_p,
  output logic [P_CNT_W-1:0] o_evt_cnt
);

  if (!lvl_is_legal(P_ACTIVE_LVL) || !lvl_is_legal(P_RST_LVL)) begin : g_bad_lvl
    $fatal(1, "sig_lvl_detect: level parameters must be \"HIGH\" or \"LOW\"");
  end
  if (P_SYNC_STAGES < 2) begin : g_bad_stages
    $fatal(1, "sig_lvl_detect: P_SYNC_STAGES must be >= 2");
  end
  if (P_DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $fatal(1, "sig_lvl_detect: P_DEBOUNCE_CYC must be >= 1");
  end

  localparam int unsigned      DbW      = $clog2(P_DEBOUNCE_CYC + 1);
  localparam logic [DbW-1:0]   DbMax    = DbW'(P_DEBOUNCE_CYC);
  localparam logic             RstRaw   = set_sig_lvl(P_RST_LVL);
  localparam logic             RstAct   = (P_RST_LVL == P_ACTIVE_LVL);
  localparam t_lvl_state       RstState = RstAct ? S_ACT : S_INACT;
  localparam logic [P_CNT_W-1:0] EvtOne = P_CNT_W'(1);

  logic sync_out;
  logic l_act;

  sig_sync #(
    .P_STAGES  (P_SYNC_STAGES),
    .P_RST_VAL (RstRaw)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_sig),
    .o_q     (sync_out)
  );

  assign l_act = lvl_is_active(sync_out, P_ACTIVE_LVL);

  t_lvl_state         state_q, state_d;
  logic [DbW-1:0]     db_cnt_q, db_cnt_d;
  logic               active_q, active_d;
  logic               assert_p_q, assert_p_d;
  logic               deassert_p_q, deassert_p_d;
  logic [P_CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    active_d     = active_q;
    assert_p_d   = 1'b0;
    deassert_p_d = 1'b0;

    unique case (state_q)
      S_INACT: begin
        if (l_act) begin
          state_d  = S_TO_ACT;
          db_cnt_d = DbW'(1);
        end
      end
      S_TO_ACT: begin
        if (!l_act) begin
          state_d  = S_INACT;
          db_cnt_d = '0;
        end else if (db_cnt_q == DbMax) begin
          state_d    = S_ACT;
          db_cnt_d   = '0;
          active_d   = 1'b1;
          assert_p_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      S_ACT: begin
        if (!l_act) begin
          state_d  = S_TO_INACT;
          db_cnt_d = DbW'(1);
        end
      end
      S_TO_INACT: begin
        if (l_act) begin
          state_d  = S_ACT;
          db_cnt_d = '0;
        end else if (db_cnt_q == DbMax) begin
          state_d      = S_INACT;
          db_cnt_d     = '0;
          active_d     = 1'b0;
          deassert_p_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = RstState;
        db_cnt_d = '0;
      end
    endcase
  end

  // A clear that coincides with a commit keeps that commit's event.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (i_clr_cnt) begin
      evt_cnt_d = assert_p_d ? EvtOne : '0;
    end else if (assert_p_d && (evt_cnt_q != '1)) begin
      evt_cnt_d = evt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= RstState;
      db_cnt_q     <= '0;
      active_q     <= RstAct;
      assert_p_q   <= 1'b0;
      deassert_p_q <= 1'b0;
      evt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      active_q     <= active_d;
      assert_p_q   <= assert_p_d;
      deassert_p_q <= deassert_p_d;
      evt_cnt_q    <= evt_cnt_d;
    end
  end

  assign o_active     = active_q;
  assign o_stable     = (state_q == S_INACT) || (state_q == S_ACT);
  assign o_assert_p   = assert_p_q;
  assign o_deassert_p = deassert_p_q;
  assign o_evt_cnt    = evt_cnt_q;

endmodule

// File: tb/tb_sig_lvl_detect.sv
// Directed bench for sig_lvl_detect: three instances cover active-high, reset-active and
// active-low configurations with a 4-cycle debounce and 2-stage synchroniser.
module tb_sig_lvl_detect;
  import common_functions::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic sig_hi = 1'b0;
  logic sig_rh = 1'b1;
  logic sig_lo = 1'b1;

  always #5 clk = ~clk;

  logic       hi_active, hi_stable, hi_assert, hi_deassert;
  logic [1:0] hi_evt;
  logic       rh_active, rh_stable, rh_assert, rh_deassert;
  logic [3:0] rh_evt;
  logic       lo_active, lo_stable, lo_assert, lo_deassert;
  logic [3:0] lo_evt;

  sig_lvl_detect #(
    .P_ACTIVE_LVL   (LvlHigh),
    .P_RST_LVL      (LvlLow),
    .P_SYNC_STAGES  (2),
    .P_DEBOUNCE_CYC (4),
    .P_CNT_W        (2)
  ) u_hi (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sig        (sig_hi),
    .i_clr_cnt    (clr),
    .o_active     (hi_active),
    .o_stable     (hi_stable),
    .o_assert_p   (hi_assert),
    .o_deassert_p (hi_deassert),
    .o_evt_cnt    (hi_evt)
  );

  sig_lvl_detect #(
    .P_ACTIVE_LVL   (LvlHigh),
    .P_RST_LVL      (LvlHigh),
    .P_SYNC_STAGES  (2),
    .P_DEBOUNCE_CYC (4),
    .P_CNT_W        (4)
  ) u_rh (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sig        (sig_rh),
    .i_clr_cnt    (clr),
    .o_active     (rh_active),
    .o_stable     (rh_stable),
    .o_assert_p   (rh_assert),
    .o_deassert_p (rh_deassert),
    .o_evt_cnt    (rh_evt)
  );

  sig_lvl_detect #(
    .P_ACTIVE_LVL   (LvlLow),
    .P_RST_LVL      (LvlHigh),
    .P_SYNC_STAGES  (2),
    .P_DEBOUNCE_CYC (4),
    .P_CNT_W        (4)
  ) u_lo (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sig        (sig_lo),
    .i_clr_cnt    (clr),
    .o_active     (lo_active),
    .o_stable     (lo_stable),
    .o_assert_p   (lo_assert),
    .o_deassert_p (lo_deassert),
    .o_evt_cnt    (lo_evt)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full assertion and release of the active-high instance.
  task automatic pulse_hi();
    sig_hi = 1'b1;
    repeat (8) tick();
    sig_hi = 1'b0;
    repeat (8) tick();
  endtask

  int pulses;

  initial begin
    #12;
    check_eq("rst_hi_active", 32'(hi_active), 0);
    check_eq("rst_hi_stable", 32'(hi_stable), 1);
    check_eq("rst_hi_evt", 32'(hi_evt), 0);
    check_eq("rst_hi_assert_p", 32'(hi_assert), 0);
    check_eq("rst_rh_active", 32'(rh_active), 1);
    check_eq("rst_lo_active", 32'(lo_active), 0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("rh_hold_active", 32'(rh_active), 1);

    // Assertion latency: pulse on edge 7 exactly.
    sig_hi = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_eq($sformatf("lat_assert_p_e%0d", e), 32'(hi_assert), 32'(e == 7));
      check_eq($sformatf("lat_active_e%0d", e), 32'(hi_active), 32'(e >= 7));
      if (e == 4) check_eq("lat_stable_e4", 32'(hi_stable), 0);
    end
    check_eq("lat_evt", 32'(hi_evt), 1);

    sig_hi = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_eq($sformatf("deas_p_e%0d", e), 32'(hi_deassert), 32'(e == 7));
    end
    check_eq("deas_active", 32'(hi_active), 0);
    check_eq("deas_evt", 32'(hi_evt), 1);

    // Glitch of three samples must be rejected.
    sig_hi = 1'b1;
    repeat (3) tick();
    sig_hi = 1'b0;
    pulses = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      pulses += int'(hi_assert) + int'(hi_deassert) + int'(hi_active);
    end
    check_eq("glitch_no_pulse", 32'(pulses), 0);
    check_eq("glitch_stable", 32'(hi_stable), 1);

    // Assertions 2..5 on a 2-bit counter saturate at 3.
    for (int k = 2; k <= 5; k++) begin
      pulse_hi();
      check_eq($sformatf("evt_after_%0d", k), 32'(hi_evt), (k > 3) ? 3 : k);
    end

    // Clear coincident with the 6th commit keeps that event.
    sig_hi = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_commit_assert_p", 32'(hi_assert), 1);
    check_eq("clr_commit_evt", 32'(hi_evt), 1);
    sig_hi = 1'b0;
    repeat (8) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_alone_evt", 32'(hi_evt), 0);

    // Reset while confirming (debounce count at 2).
    pulse_hi();
    check_eq("pre_rst_evt", 32'(hi_evt), 1);
    sig_hi = 1'b1;
    repeat (4) tick();
    check_eq("mid_confirm_stable", 32'(hi_stable), 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_active", 32'(hi_active), 0);
    check_eq("mid_rst_stable", 32'(hi_stable), 1);
    check_eq("mid_rst_evt", 32'(hi_evt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) pulses += int'(hi_assert);
    end
    check_eq("post_rst_no_early_pulse", 32'(pulses), 0);
    check_eq("post_rst_assert_p", 32'(hi_assert), 1);
    check_eq("post_rst_evt", 32'(hi_evt), 1);

    // Active-low polarity.
    sig_lo = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_eq($sformatf("lo_assert_p_e%0d", e), 32'(lo_assert), 32'(e == 7));
      check_eq($sformatf("lo_active_e%0d", e), 32'(lo_active), 32'(e >= 7));
    end
    check_eq("lo_evt", 32'(lo_evt), 1);
    sig_lo = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_eq($sformatf("lo_deassert_p_e%0d", e), 32'(lo_deassert), 32'(e == 7));
    end
    check_eq("lo_final_active", 32'(lo_active), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
